// File: rtl/out_port_pkg.sv
// Shared types and constants for the CPU-to-pin output port.
// Addresses default to the AVR I/O map slots used by this port.
package out_port_pkg;

    typedef enum logic {
        IDLE    = 1'b0,
        PRESENT = 1'b1
    } state_t;

    localparam logic [5:0] DEF_PORT_ADDR = 6'h18;
    localparam logic [5:0] DEF_STAT_ADDR = 6'h17;

    localparam int ST_OVF   = 7;
    localparam int ST_FULL  = 6;
    localparam int ST_EMPTY = 5;
    localparam int ST_VALID = 4;
    localparam int ST_CNT_W = 4;

    function automatic logic [7:0] pack_status(
        input logic                ovf,
        input logic                full,
        input logic                empty,
        input logic                valid,
        input logic [ST_CNT_W-1:0] cnt
    );
        logic [7:0] s;
        s                 = '0;
        s[ST_OVF]         = ovf;
        s[ST_FULL]        = full;
        s[ST_EMPTY]       = empty;
        s[ST_VALID]       = valid;
        s[ST_CNT_W-1:0]   = cnt;
        return s;
    endfunction

endpackage

// File: rtl/port_fifo.sv
// Small synchronous FIFO with head-of-queue output and occupancy count.
// Push while full and pop while empty are ignored internally as a safety net.
module port_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4,
    parameter int PTR_W  = $clog2(DEPTH),
    parameter int CNT_W  = PTR_W + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout,
    output logic              full,
    output logic              empty,
    output logic [CNT_W-1:0]  count
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              do_push;
    logic              do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    // Storage is not reset; count and pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/out_port_fifo.sv
// Output port: I/O-mapped byte writes are queued and presented on the pins
// under a valid/ack handshake, with a pollable status register.
module out_port_fifo
    import out_port_pkg::*;
#(
    parameter int                DATA_W    = 8,
    parameter int                DEPTH     = 4,
    parameter int                ADDR_W    = 6,
    parameter logic [ADDR_W-1:0] PORT_ADDR = ADDR_W'(DEF_PORT_ADDR),
    parameter logic [ADDR_W-1:0] STAT_ADDR = ADDR_W'(DEF_STAT_ADDR)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              wr_ready,
    output logic [DATA_W-1:0] pin_out,
    output logic              pin_valid,
    input  logic              pin_ack,
    output state_t            dbg_state
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    // Handshake: pin_out is taken by the sink at a rising edge where
    // pin_valid and pin_ack are both 1; pin_ack with pin_valid low is ignored.

    logic              push_hit;
    logic              stat_hit;
    logic              push;
    logic              pop;
    logic              load;
    logic [DATA_W-1:0] head;
    logic              full;
    logic              empty;
    logic [CNT_W-1:0]  count;
    logic              ovf;
    logic [7:0]        status;
    state_t            state;
    state_t            state_nxt;

    assign push_hit = wr_en && (wr_addr == PORT_ADDR);
    assign stat_hit = wr_en && (wr_addr == STAT_ADDR);
    assign push     = push_hit && !full;
    assign wr_ready = !full;

    port_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .din   (wr_data),
        .dout  (head),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    // full is sampled before any same-cycle pop, so such a push is still lost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf <= 1'b0;
        end else if (push_hit && full) begin
            ovf <= 1'b1;
        end else if (stat_hit) begin
            ovf <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        load      = 1'b0;
        case (state)
            IDLE: begin
                if (!empty) begin
                    load      = 1'b1;
                    pop       = 1'b1;
                    state_nxt = PRESENT;
                end
            end
            PRESENT: begin
                if (pin_ack) begin
                    if (!empty) begin
                        load = 1'b1;
                        pop  = 1'b1;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // pin_out is latched: it keeps the last byte after pin_valid drops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pin_out <= '0;
        end else if (load) begin
            pin_out <= head;
        end
    end

    assign pin_valid = (state == PRESENT);
    assign dbg_state = state;

    always_comb begin
        status  = pack_status(ovf, full, empty, pin_valid, ST_CNT_W'(count));
        rd_data = '0;
        if (rd_addr == PORT_ADDR) begin
            rd_data = pin_out;
        end else if (rd_addr == STAT_ADDR) begin
            rd_data = DATA_W'(status);
        end
    end

endmodule

// File: tb/tb_out_port_fifo.sv
// Bench for out_port_fifo: directed scenarios plus random traffic checked
// against a queue-based model of the port.
module tb_out_port_fifo;
    import out_port_pkg::*;

    localparam int         DEPTH = 4;
    localparam logic [5:0] PA    = 6'h18;
    localparam logic [5:0] SA    = 6'h17;

    logic       clk;
    logic       rst_n;
    logic       wr_en;
    logic [5:0] wr_addr;
    logic [7:0] wr_data;
    logic [5:0] rd_addr;
    logic [7:0] rd_data;
    logic       wr_ready;
    logic [7:0] pin_out;
    logic       pin_valid;
    logic       pin_ack;
    state_t     dbg_state;

    int tests;
    int failed;

    // Reference model
    logic [7:0] exp_q[$];
    logic [7:0] m_pin;
    logic       m_valid;
    logic       m_ovf;

    out_port_fifo dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .wr_ready  (wr_ready),
        .pin_out   (pin_out),
        .pin_valid (pin_valid),
        .pin_ack   (pin_ack),
        .dbg_state (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        if (obs !== exp) begin
            failed++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] exp_status();
        int n;
        n = exp_q.size();
        return {m_ovf, (n == DEPTH), (n == 0), m_valid, 4'(n)};
    endfunction

    task automatic model_reset();
        exp_q.delete();
        m_pin   = 8'h00;
        m_valid = 1'b0;
        m_ovf   = 1'b0;
    endtask

    // One rising edge of the port as described by its rules.
    task automatic model_edge(input logic we, input logic [5:0] wa,
                              input logic [7:0] wd, input logic ack);
        int  pre_n;
        bit  pre_full;
        pre_n    = exp_q.size();
        pre_full = (pre_n == DEPTH);
        if (!m_valid) begin
            if (pre_n > 0) begin
                m_pin   = exp_q.pop_front();
                m_valid = 1'b1;
            end
        end else if (ack) begin
            if (pre_n > 0) m_pin = exp_q.pop_front();
            else           m_valid = 1'b0;
        end
        if (we && wa == PA) begin
            if (pre_full) m_ovf = 1'b1;
            else          exp_q.push_back(wd);
        end else if (we && wa == SA) begin
            m_ovf = 1'b0;
        end
    endtask

    task automatic check_outputs(input string tag);
        logic [5:0] other;
        check({tag, "_valid"}, 32'(pin_valid), 32'(m_valid));
        check({tag, "_pin"}, 32'(pin_out), 32'(m_pin));
        check({tag, "_ready"}, 32'(wr_ready), 32'(exp_q.size() != DEPTH));
        check({tag, "_state"}, 32'(dbg_state), m_valid ? 32'(PRESENT) : 32'(IDLE));
        rd_addr = SA;
        #1;
        check({tag, "_stat"}, 32'(rd_data), 32'(exp_status()));
        rd_addr = PA;
        #1;
        check({tag, "_rdport"}, 32'(rd_data), 32'(m_pin));
        other = 6'($urandom_range(0, 63));
        while (other == PA || other == SA) other = 6'($urandom_range(0, 63));
        rd_addr = other;
        #1;
        check({tag, "_unmapped"}, 32'(rd_data), 32'h0);
    endtask

    task automatic step(input string tag, input logic we, input logic [5:0] wa,
                        input logic [7:0] wd, input logic ack);
        wr_en   = we;
        wr_addr = wa;
        wr_data = wd;
        pin_ack = ack;
        @(posedge clk);
        model_edge(we, wa, wd, ack);
        #1;
        wr_en   = 1'b0;
        pin_ack = 1'b0;
        check_outputs(tag);
    endtask

    task automatic read_stat(input string tag, input logic [7:0] exp);
        rd_addr = SA;
        #1;
        check(tag, 32'(rd_data), 32'(exp));
    endtask

    initial begin
        tests   = 0;
        failed  = 0;
        rst_n   = 1'b0;
        wr_en   = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        rd_addr = '0;
        pin_ack = 1'b0;
        model_reset();

        // 1. reset state
        #12;
        @(negedge clk);
        rst_n = 1'b1;
        read_stat("t1_stat", 8'h20);
        check("t1_pin", 32'(pin_out), 32'h0);
        check("t1_valid", 32'(pin_valid), 32'h0);

        // 2. single byte, latency, hold, one-cycle ack
        step("t2_push", 1'b1, PA, 8'hA5, 1'b0);
        check("t2_lat_n", 32'(pin_valid), 32'h0);
        step("t2_n1", 1'b0, PA, 8'h00, 1'b0);
        check("t2_lat_n1", 32'(pin_valid), 32'h1);
        for (int i = 0; i < 10; i++) step("t2_hold", 1'b0, PA, 8'h00, 1'b0);
        check("t2_held", 32'(pin_out), 32'hA5);
        step("t2_ack", 1'b0, PA, 8'h00, 1'b1);
        check("t2_drop", 32'(pin_valid), 32'h0);
        check("t2_latched", 32'(pin_out), 32'hA5);

        // 3. fill, overflow, clear
        for (int i = 1; i <= 5; i++) step("t3_fill", 1'b1, PA, 8'(i), 1'b0);
        check("t3_ready", 32'(wr_ready), 32'h0);
        read_stat("t3_stat_full", 8'h54);
        step("t3_ovf", 1'b1, PA, 8'h06, 1'b0);
        read_stat("t3_stat_ovf", 8'hD4);
        step("t3_clr", 1'b1, SA, 8'hFF, 1'b0);
        read_stat("t3_stat_clr", 8'h54);

        // 4. drain back-to-back with ack held high
        for (int i = 2; i <= 5; i++) begin
            step("t4_drain", 1'b0, PA, 8'h00, 1'b1);
            check("t4_byte", 32'(pin_out), 32'(i));
        end
        step("t4_end", 1'b0, PA, 8'h00, 1'b1);
        check("t4_idle", 32'(dbg_state), 32'(IDLE));
        check("t4_valid", 32'(pin_valid), 32'h0);

        // 5. push while full with a same-cycle pop
        for (int i = 0; i < 5; i++) step("t5_fill", 1'b1, PA, 8'(8'h10 + i), 1'b0);
        step("t5_pushpop", 1'b1, PA, 8'h77, 1'b1);
        read_stat("t5_stat", 8'h93);

        // 6. asynchronous reset mid-stream
        step("t6_clr", 1'b1, SA, 8'h00, 1'b0);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check("t6_pin", 32'(pin_out), 32'h0);
        check("t6_valid", 32'(pin_valid), 32'h0);
        check("t6_ready", 32'(wr_ready), 32'h1);
        @(negedge clk);
        rst_n = 1'b1;
        step("t6_after", 1'b0, PA, 8'h00, 1'b0);
        read_stat("t6_stat", 8'h20);

        // random traffic
        for (int i = 0; i < 400; i++) begin
            logic       we;
            logic [5:0] wa;
            logic       ack;
            int         sel;
            we  = ($urandom_range(0, 99) < 60);
            sel = $urandom_range(0, 9);
            wa  = (sel < 7) ? PA : (sel < 9) ? SA : 6'($urandom_range(0, 16));
            ack = ($urandom_range(0, 99) < ((i / 50) % 2 == 0 ? 30 : 70));
            step("rnd", we, wa, 8'($urandom_range(0, 255)), ack);
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
